instr_fetch_buffer: RTL and testbench

//  Sits between the PC/Fetch stage and the instruction decoder.
//  - Takes the current PC, reads instruction memory over a req/gnt/rvalid handshake and queues {pc, instr} pairs.
//  - Presents queued pairs to Decode with valid/ready.
//  - Returns a PC-advance enable to Fetch and discards stale work on a taken branch (flush).

---
 rtl/ifb_pkg.sv | 18 +
 rtl/ifb_fifo.sv | 71 +++++++
 rtl/instr_fetch_buffer.sv | 134 +++++++++++++
 tb/tb_instr_fetch_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM state encodings
// and a width helper for the occupancy counter.
package ifb_pkg;

  // One outstanding read: IDLE may request, WAIT holds the in-flight read,
  // DROP swallows the response of a read that a flush made stale.
  typedef enum logic [1:0] {
    IFB_IDLE = 2'd0,
    IFB_WAIT = 2'd1,
    IFB_DROP = 2'd2
  } ifb_state_e;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the fetch buffer.
// Power-of-two depth so the pointers wrap naturally. Flush empties the
// queue and overrides push and pop in the same cycle.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Qualify requests: never pop an empty queue, push into a full queue
  // only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer, count and storage update; flush has priority over push/pop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer between Fetch and Decode.
// Reads instruction memory one request at a time for the current PC,
// queues {pc, instr} pairs and hands them to Decode. A taken branch
// (flush) discards queued and in-flight work.
// Optional build macro IFB_BYPASS_EN: a response arriving into an empty
// queue is presented to Decode combinationally in the same cycle.
//
// Handshakes: imem_req/imem_gnt - a request is accepted on a cycle where
// both are high; imem_req, once raised, stays high with imem_addr stable
// until granted (unless a flush withdraws it). imem_rvalid carries one
// response per accepted request. dec_valid/dec_ready - an entry transfers
// on a cycle where both are high; while dec_valid is high and dec_ready
// low, dec_instr/dec_pc are held stable.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [AW-1:0]          fetch_addr,
  output logic                   fetch_adv,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [DW-1:0]          imem_rdata,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [DW-1:0]          dec_instr,
  output logic [AW-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [1:0]             fsm_state
);

  localparam int ENTRY_W = AW + DW;
  localparam int CW      = occ_width(DEPTH);

  ifb_state_e        state;
  logic [AW-1:0]     pend_pc;

  logic [ENTRY_W-1:0] q_head;
  logic               q_empty;
  logic [CW-1:0]      q_count;
  logic               q_push;
  logic               q_pop;
  logic               credit_ok;
  logic               rd_accept;

  // With a single outstanding read, an IDLE request only needs a free slot
  // in the queue; the in-flight read is then the only thing that can fill it.
  assign credit_ok = (q_count < CW'(DEPTH));

  // Request is gated by Reset so it reads low while reset is asserted.
  assign imem_req  = Reset && (state == IFB_IDLE) && !flush && credit_ok;
  assign imem_addr = fetch_addr;

  // Fetch advances once per accepted request, and on a flush so it can
  // load the branch target.
  assign fetch_adv = (imem_req && imem_gnt) || flush;

  // A response is kept only when it belongs to a live (non-flushed) read.
  assign rd_accept = (state == IFB_WAIT) && imem_rvalid && !flush;

  assign occupancy = q_count;
  assign fsm_state = state;

  // Push/pop selection and decode-side output mux.
  always_comb begin
    q_push    = rd_accept;
    q_pop     = !q_empty && dec_ready;
    dec_valid = !q_empty;
    dec_pc    = q_head[ENTRY_W-1:DW];
    dec_instr = q_head[DW-1:0];
`ifdef IFB_BYPASS_EN
    if (rd_accept && q_empty) begin
      dec_valid = 1'b1;
      dec_pc    = pend_pc;
      dec_instr = imem_rdata;
      // Consumed directly by Decode: do not also write it to the queue.
      q_push    = !dec_ready;
    end
`endif
  end

  // Read-tracking FSM: one outstanding read, stale responses dropped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IFB_IDLE;
      pend_pc <= '0;
    end else begin
      case (state)
        IFB_IDLE: begin
          if (imem_req && imem_gnt) begin
            pend_pc <= fetch_addr;
            state   <= IFB_WAIT;
          end
        end
        IFB_WAIT: begin
          if (flush) begin
            state <= imem_rvalid ? IFB_IDLE : IFB_DROP;
          end else if (imem_rvalid) begin
            state <= IFB_IDLE;
          end
        end
        IFB_DROP: begin
          if (imem_rvalid) begin
            state <= IFB_IDLE;
          end
        end
        default: state <= IFB_IDLE;
      endcase
    end
  end

  ifb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (q_push),
    .push_data ({pend_pc, imem_rdata}),
    .pop       (q_pop),
    .flush     (flush),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a scoreboard of expected
// {pc, instr} pairs popped whenever Decode accepts an entry.
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int EW    = AW + DW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic [AW-1:0]          fetch_addr = '0;
  logic                   fetch_adv;
  logic                   flush = 1'b0;
  logic                   imem_req;
  logic [AW-1:0]          imem_addr;
  logic                   imem_gnt = 1'b0;
  logic                   imem_rvalid = 1'b0;
  logic [DW-1:0]          imem_rdata = '0;
  logic                   dec_valid;
  logic                   dec_ready = 1'b0;
  logic [DW-1:0]          dec_instr;
  logic [AW-1:0]          dec_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic [1:0]             fsm_state;

  instr_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .fetch_addr  (fetch_addr),
    .fetch_adv   (fetch_adv),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .occupancy   (occupancy),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Decode-side monitor: sample late in the cycle, just before the edge.
  always @(negedge Clock) begin
    logic [EW-1:0] item;
    #4;
    if (Reset && dec_valid === 1'b1 && dec_ready && !flush) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=0x%0h expected=none", {dec_pc, dec_instr});
      end
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        check("sb_entry", {dec_pc, dec_instr}, item);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge Clock);
  endtask

  // Wait for a request (bounded), grant it, advance the Fetch model.
  task automatic grant(output logic [AW-1:0] pc);
    int guard;
    guard = 0;
    #1;
    while (imem_req !== 1'b1 && guard < 40) begin
      next_cycle();
      #1;
      guard++;
    end
    check("grant_req_seen", imem_req, 1'b1);
    check("grant_addr", imem_addr, fetch_addr);
    pc = fetch_addr;
    imem_gnt = 1'b1;
    #1;
    check("grant_adv", fetch_adv, 1'b1);
    next_cycle();
    imem_gnt   = 1'b0;
    fetch_addr = fetch_addr + 32'd4;
  endtask

  task automatic respond(input logic [AW-1:0] pc, input logic [DW-1:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back({pc, data});
    next_cycle();
    imem_rvalid = 1'b0;
  endtask

  task automatic mem_read(input int lat, input logic [DW-1:0] data);
    logic [AW-1:0] pc;
    grant(pc);
    repeat (lat - 1) next_cycle();
    respond(pc, data);
  endtask

  task automatic drain(input string tag);
    dec_ready = 1'b1;
    repeat (DEPTH + 2) next_cycle();
    dec_ready = 1'b0;
    #1;
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_valid"}, dec_valid, 1'b0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_adv"}, fetch_adv, 1'b0);
    check({tag, "_valid"}, dec_valid, 1'b0);
    check({tag, "_instr"}, dec_instr, 0);
    check({tag, "_pc"}, dec_pc, 0);
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] pc;

    repeat (2) next_cycle();
    #1;
    check_reset_values("rst");

    // T1: first fetch, gnt at cycle 1, rvalid at cycle 3.
    next_cycle();
    Reset = 1'b1;
    #1;
    check("t1_req_c0", imem_req, 1'b1);
    check("t1_adv_c0", fetch_adv, 1'b0);
    next_cycle();
    imem_gnt = 1'b1;
    #1;
    check("t1_adv_c1", fetch_adv, 1'b1);
    check("t1_addr_c1", imem_addr, 0);
    next_cycle();
    imem_gnt   = 1'b0;
    fetch_addr = 32'd4;
    #1;
    check("t1_req_c2", imem_req, 1'b0);
    check("t1_adv_c2", fetch_adv, 1'b0);
    check("t1_state_c2", fsm_state, ST_WAIT);
    next_cycle();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    exp_q.push_back({32'h0, 32'h2008_0005});
    #1;
`ifdef IFB_BYPASS_EN
    check("t1_valid_c3", dec_valid, 1'b1);
    check("t1_instr_c3", dec_instr, 32'h2008_0005);
`else
    check("t1_valid_c3", dec_valid, 1'b0);
`endif
    next_cycle();
    imem_rvalid = 1'b0;
    #1;
    check("t1_valid_c4", dec_valid, 1'b1);
    check("t1_pc_c4", dec_pc, 0);
    check("t1_instr_c4", dec_instr, 32'h2008_0005);
    check("t1_occ_c4", occupancy, 1);
    next_cycle();
    dec_ready = 1'b1;
    next_cycle();
    dec_ready = 1'b0;
    #1;
    check("t1_occ_after_pop", occupancy, 0);
    check("t1_valid_after_pop", dec_valid, 1'b0);

    // T2: decoder stalled, memory answers every 2 cycles -> fills up.
    next_cycle();
    for (int i = 0; i < 4; i++) mem_read(2, 32'h1000_0000 + i);
    #1;
    check("t2_occ_full", occupancy, 4);
    check("t2_req_full", imem_req, 1'b0);
    check("t2_head_pc", dec_pc, 32'h4);
    check("t2_head_instr", dec_instr, 32'h1000_0000);
    next_cycle();
    #1;
    check("t2_req_still_full", imem_req, 1'b0);
    check("t2_head_held", dec_pc, 32'h4);
    next_cycle();
    dec_ready = 1'b1;
    next_cycle();
    dec_ready = 1'b0;
    #1;
    check("t2_req_reenabled", imem_req, 1'b1);
    check("t2_occ_after_pop", occupancy, 3);
    drain("t2_drain");

    // T3: flush while WAIT, stale rvalid two cycles later.
    next_cycle();
    mem_read(1, 32'h3000_0001);
    grant(pc);
    flush = 1'b1;
    exp_q.delete();
    #1;
    check("t3_flush_adv", fetch_adv, 1'b1);
    check("t3_flush_req", imem_req, 1'b0);
    next_cycle();
    flush      = 1'b0;
    fetch_addr = 32'h100;
    #1;
    check("t3_state_drop", fsm_state, ST_DROP);
    check("t3_occ_zero", occupancy, 0);
    check("t3_valid_zero", dec_valid, 1'b0);
    check("t3_req_drop", imem_req, 1'b0);
    next_cycle();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    dec_ready   = 1'b1;
    #1;
    check("t3_stale_hidden", dec_valid, 1'b0);
    next_cycle();
    imem_rvalid = 1'b0;
    dec_ready   = 1'b0;
    #1;
    check("t3_state_idle", fsm_state, ST_IDLE);
    check("t3_req_target", imem_req, 1'b1);
    check("t3_addr_target", imem_addr, 32'h100);
    check("t3_no_stale", dec_valid, 1'b0);
    next_cycle();
    mem_read(1, 32'h3000_0002);
    #1;
    check("t3_new_pc", dec_pc, 32'h100);
    drain("t3_drain");

    // T4: flush coinciding with rvalid and dec_ready at occupancy 2.
    next_cycle();
    mem_read(1, 32'h4000_0001);
    mem_read(1, 32'h4000_0002);
    #1;
    check("t4_occ_two", occupancy, 2);
    next_cycle();
    grant(pc);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4000_0003;
    dec_ready   = 1'b1;
    flush       = 1'b1;
    exp_q.delete();
    next_cycle();
    imem_rvalid = 1'b0;
    dec_ready   = 1'b0;
    flush       = 1'b0;
    fetch_addr  = 32'h200;
    #1;
    check("t4_occ_zero", occupancy, 0);
    check("t4_valid_zero", dec_valid, 1'b0);
    check("t4_state_idle", fsm_state, ST_IDLE);

    // T5: full queue cycled through pointer wrap, PCs 0x0..0x1C in order.
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush      = 1'b0;
    fetch_addr = 32'h0;
    for (int i = 0; i < 4; i++) mem_read(1, 32'h5000_0000 + 32'(i));
    #1;
    check("t5_occ_full", occupancy, 4);
    for (int i = 4; i < 8; i++) begin
      next_cycle();
      dec_ready = 1'b1;
      next_cycle();
      dec_ready = 1'b0;
      mem_read(1, 32'h5000_0000 + 32'(i));
      #1;
      check("t5_occ_refill", occupancy, 4);
    end
    next_cycle();
    dec_ready = 1'b1;
    next_cycle();
    dec_ready = 1'b0;
    grant(pc);
    dec_ready = 1'b1;
    respond(pc, 32'h5000_0008);
    dec_ready = 1'b0;
    #1;
    check("t5_push_pop_occ", occupancy, 3);
    drain("t5_drain");

    // T6: reset asserted during WAIT, response arrives after release.
    next_cycle();
    mem_read(1, 32'h6000_0001);
    next_cycle();
    grant(pc);
    Reset = 1'b0;
    exp_q.delete();
    fetch_addr = 32'h0;
    #1;
    check_reset_values("t6_rst");
    next_cycle();
    Reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("t6_late_rvalid_hidden", dec_valid, 1'b0);
    next_cycle();
    imem_rvalid = 1'b0;
    #1;
    check("t6_valid_zero", dec_valid, 1'b0);
    check("t6_occ_zero", occupancy, 0);
    check("t6_state_idle", fsm_state, ST_IDLE);
    check("t6_req_resumes", imem_req, 1'b1);

    next_cycle();
    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
